clock_checkout_scheduler: RTL
=============================

// Module: clock_checkout_scheduler
// PURPOSE
//  Sequences a bank of NCH board-clock checkout counters from sysclk. Generates the shared
//  sysclk_millice measurement tick, and on each start runs NSWEEPS measurement windows.
//  Checks every channel's per-window count against a [min,max] window and reports
//  per-channel pass/dead flags. Sits between the checkout counters and the board-test VIO.
// PARAMETERS
//  NCH            4       number of checkout channels (1..16)
//  CNT_W          48      width of each count
//  SYSCLK_PER_MS  100000  sysclk cycles per tick period; must be >= NCH+4
//  NSWEEPS        8       windows checked per run (1..255)
// PORTS
//  sysclk          in   1          system clock, sole clock
//  rst_n           in   1          asynchronous active-low reset
//  start           in   1          1-cycle pulse; begins a run if idle, ignored while busy
//  abort           in   1          level; returns FSM to IDLE next cycle, no done pulse
//  count_in        in   NCH*CNT_W  current_count of channel i at [i*CNT_W +: CNT_W]
//  min_count       in   NCH*CNT_W  per-channel lower bound, inclusive
//  max_count       in   NCH*CNT_W  per-channel upper bound, inclusive
//  sysclk_millice  out  1          1-cycle tick to all checkout channels
//  busy            out  1          high from cycle after accepted start until done
//  done            out  1          1-cycle pulse, run complete, pass/dead valid
//  pass            out  NCH        channel i within window on every checked sweep
//  dead            out  NCH        channel i read count==0 on any checked sweep
//  sweep_idx       out  8          sweeps completed in current/last run
// BEHAVIOUR
//  Reset: all outputs 0, tick counter 0, FSM IDLE, pass/dead 0.
//  Tick: free-running modulo-SYSCLK_PER_MS counter, never gated by start/abort.
//   sysclk_millice=1 for exactly the cycle the counter equals SYSCLK_PER_MS-1, then wraps to 0.
//  Data rule: count_in updates on the tick edge and holds the window ending at the
//   previous tick, so the first tick after start is discarded (PRIME).
//  FSM:
//   IDLE   -start-> PRIME; clear pass to all-1, dead to 0, sweep_idx to 0; busy=1.
//   PRIME  -tick-> WAIT
//   WAIT   -tick-> SETTLE
//   SETTLE 1 cycle (count_in now stable) -> CHECK with ch=0
//   CHECK  1 channel/cycle: in = min<=count<=max (unsigned, full CNT_W compare);
//          pass[ch] &= in; dead[ch] |= (count==0); ch==NCH-1 -> sweep_idx++ ->
//          (sweep_idx+1==NSWEEPS ? REPORT : WAIT)
//   REPORT done=1 one cycle, busy=0 same cycle -> IDLE
//  Latency: done asserts NSWEEPS+1 ticks + NCH+2 cycles after start accepted,
//   plus alignment wait (0..SYSCLK_PER_MS-1) to the first tick.
//  start coincident with tick while IDLE: that tick is NOT the prime; next tick is.
//  Tick arriving during CHECK cannot occur (NCH+4 constraint); in WAIT, extra ticks are not possible.
//  abort wins over start and all transitions; pass/dead/sweep_idx keep partial values,
//   busy drops next cycle. pass is only meaningful qualified by done.
//  pass/dead/sweep_idx hold after REPORT until the next accepted start.
//  min>max for a channel: window empty, channel fails. Reset mid-run: immediate IDLE.
// TESTING
//  SYSCLK_PER_MS=20,NCH=4: free run 100 cyc -> millice at cycles 19,39,59,79,99 only.
//  Counts 1000 each, min 990 max 1010, NSWEEPS=3 -> done once, pass=4'hF, dead=0, sweep_idx=3.
//  Ch2 reads 1011 on sweep 2 only -> pass=4'hB; ch1 reads 0 on one sweep -> dead=4'h2, pass[1]=0.
//  count==min and count==max exactly, with CNT_W MSB set -> pass bit stays 1.
//  abort during CHECK of sweep 1 -> busy=0 next cycle, no done; new start -> clean pass=4'hF run.
//  start during busy ignored; start on tick cycle -> done one tick later than start one cycle prior.

Source files
------------

// File: rtl/clock_checkout_scheduler.sv
// Checkout scheduler: generates the shared measurement tick and, per run,
// checks every channel's per-window count against its [min,max] bounds.
module clock_checkout_scheduler #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned CNT_W         = 48,
  parameter int unsigned SYSCLK_PER_MS = 100000,
  parameter int unsigned NSWEEPS       = 8
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NCH*CNT_W-1:0] count_in,
  input  logic [NCH*CNT_W-1:0] min_count,
  input  logic [NCH*CNT_W-1:0] max_count,
  output logic                 sysclk_millice,
  output logic                 busy,
  output logic                 done,
  output logic [NCH-1:0]       pass,
  output logic [NCH-1:0]       dead,
  output logic [7:0]           sweep_idx
);

  localparam int unsigned TICK_W = (SYSCLK_PER_MS > 1) ? $clog2(SYSCLK_PER_MS) : 1;
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SYSCLK_PER_MS - 1);
  localparam logic [TICK_W-1:0] TICK_PRE   = TICK_W'(SYSCLK_PER_MS - 2);
  localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(NCH - 1);
  localparam logic [7:0]        SWEEP_LAST = 8'(NSWEEPS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4,
    REPORT = 3'd5
  } state_t;

  logic [TICK_W-1:0] tick_cnt;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch, ch_nxt;
  logic [NCH-1:0]    pass_nxt, dead_nxt;
  logic [7:0]        sweep_nxt;
  logic              busy_nxt, done_nxt;

  logic [CNT_W-1:0]  cnt_arr [NCH];
  logic [CNT_W-1:0]  min_arr [NCH];
  logic [CNT_W-1:0]  max_arr [NCH];
  logic [CNT_W-1:0]  cur_cnt, cur_min, cur_max;
  logic              in_win, is_zero;

  // Unpack the flat per-channel buses into indexable arrays
  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign cnt_arr[g] = count_in[g*CNT_W +: CNT_W];
    assign min_arr[g] = min_count[g*CNT_W +: CNT_W];
    assign max_arr[g] = max_count[g*CNT_W +: CNT_W];
  end

  assign cur_cnt = cnt_arr[ch];
  assign cur_min = min_arr[ch];
  assign cur_max = max_arr[ch];
  assign in_win  = (cur_cnt >= cur_min) && (cur_cnt <= cur_max);
  assign is_zero = (cur_cnt == '0);

  // Free-running tick counter; millice is registered one cycle ahead so it is
  // high exactly while the counter sits at its last value
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt       <= '0;
      sysclk_millice <= 1'b0;
    end else begin
      tick_cnt       <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
      sysclk_millice <= (tick_cnt == TICK_PRE);
    end
  end

  // Run sequencer: next state, next flags and next registered outputs
  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    pass_nxt  = pass;
    dead_nxt  = dead;
    sweep_nxt = sweep_idx;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    if (abort) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = PRIME;
            pass_nxt  = '1;
            dead_nxt  = '0;
            sweep_nxt = 8'd0;
            busy_nxt  = 1'b1;
          end
        end
        PRIME: begin
          if (sysclk_millice) state_nxt = WAIT;
        end
        WAIT: begin
          if (sysclk_millice) state_nxt = SETTLE;
        end
        SETTLE: begin
          state_nxt = CHECK;
          ch_nxt    = '0;
        end
        CHECK: begin
          pass_nxt[ch] = pass[ch] & in_win;
          dead_nxt[ch] = dead[ch] | is_zero;
          if (ch == CH_LAST) begin
            sweep_nxt = sweep_idx + 8'd1;
            if (sweep_idx == SWEEP_LAST) begin
              state_nxt = REPORT;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = WAIT;
            end
          end else begin
            ch_nxt = ch + CH_W'(1);
          end
        end
        REPORT: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch        <= '0;
      pass      <= '0;
      dead      <= '0;
      sweep_idx <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ch        <= ch_nxt;
      pass      <= pass_nxt;
      dead      <= dead_nxt;
      sweep_idx <= sweep_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule
